// File: rtl/peripheral_dma.sv
// Single-channel memory-to-memory DMA with a CPU register port and a simple
// strobe/busy bus-master port; copies LEN words from SRC to DST one word at a time.
module peripheral_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic [31:0] m_addr,
    output logic        m_rstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_rbusy,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    input  logic        m_wbusy,
    output logic        irq
);

    localparam logic [4:0] A_SRC    = 5'h00;
    localparam logic [4:0] A_DST    = 5'h04;
    localparam logic [4:0] A_LEN    = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
    localparam logic [4:0] A_REMAIN = 5'h14;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, dst_q, wsrc_q, wdst_q, data_q, dout_q;
    logic [15:0] len_q, remain_q;
    logic        done_q, aborted_q, abort_q;

    logic        wr_en, rd_en, busy, start_wr, abort_wr;
    logic        start_go, start_zero, rd_done, wr_done, finish;
    logic [15:0] remain_dec;
    logic [31:0] rd_mux;

    assign wr_en      = cs & wr;
    assign rd_en      = cs & rd;
    assign busy       = (state_q != IDLE);
    assign start_wr   = wr_en && (addr == A_CTRL) && d_in[0];
    assign abort_wr   = wr_en && (addr == A_CTRL) && d_in[1];
    assign start_go   = start_wr && !busy && (len_q != 16'd0);
    assign start_zero = start_wr && !busy && (len_q == 16'd0);
    assign rd_done    = (state_q == RD_WAIT) && !m_rbusy;
    assign wr_done    = (state_q == WR_WAIT) && !m_wbusy;
    assign remain_dec = remain_q - 16'd1;
    // A pending abort is honoured only once the current word's write has landed.
    assign finish     = wr_done && ((remain_dec == 16'd0) || abort_q || abort_wr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RD_REQ;
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (!m_rbusy) state_d = WR_REQ;
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: if (!m_wbusy) state_d = finish ? IDLE : RD_REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_addr  = '0;
        m_rstrb = 1'b0;
        m_wdata = '0;
        m_wmask = 4'b0000;
        case (state_q)
            RD_REQ: begin
                m_addr  = wsrc_q;
                m_rstrb = 1'b1;
            end
            WR_REQ: begin
                m_addr  = wdst_q;
                m_wdata = data_q;
                m_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr)
            A_SRC:    rd_mux = src_q;
            A_DST:    rd_mux = dst_q;
            A_LEN:    rd_mux = {16'h0000, len_q};
            A_STATUS: rd_mux = {29'h0, aborted_q, done_q, busy};
            A_REMAIN: rd_mux = {16'h0000, remain_q};
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            wsrc_q    <= '0;
            wdst_q    <= '0;
            remain_q  <= '0;
            data_q    <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (addr)
                    A_SRC:   src_q <= {d_in[31:2], 2'b00};
                    A_DST:   dst_q <= {d_in[31:2], 2'b00};
                    A_LEN:   len_q <= d_in[15:0];
                    default: ;
                endcase
            end
            if (start_go) begin
                wsrc_q    <= src_q;
                wdst_q    <= dst_q;
                remain_q  <= len_q;
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
                abort_q   <= 1'b0;
            end
            if (start_zero) begin
                done_q    <= 1'b1;
                aborted_q <= 1'b0;
            end
            if (busy && abort_wr) abort_q <= 1'b1;
            if (rd_done) data_q <= m_rdata;
            if (wr_done) begin
                wsrc_q   <= wsrc_q + 32'd4;
                wdst_q   <= wdst_q + 32'd4;
                remain_q <= remain_dec;
            end
            if (finish) begin
                done_q    <= 1'b1;
                aborted_q <= abort_q | abort_wr;
                abort_q   <= 1'b0;
            end
            if (rd_en) dout_q <= rd_mux;
        end
    end

    assign d_out = dout_q;
    assign irq   = done_q;

endmodule
